// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_outq register block: control-word bit
// positions, select-width helper and the reset level.
package regfile_pkg;

  // Bit positions of the decoder control word that drives this block.
  typedef enum int unsigned {
    CW_LOAD   = 0,
    CW_ASSERT = 1,
    CW_OUT    = 2
  } cw_bit_e;

  localparam int CW_BITS = 3;

  // Reset is a synchronous, active-high level.
  localparam logic RESET_ACTIVE = 1'b1;

  // Register-select width; a single register still needs a one-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_outq_out_queue.sv
// out_queue: QDEPTH-entry circular output buffer with valid/ready handshake,
// registered occupancy/full flags and a sticky overflow flag.
module out_queue
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_req,
  input  logic [WIDTH-1:0]          din,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          qreg,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [$clog2(QDEPTH):0]   out_count,
  output logic                      out_full,
  output logic                      out_ovf
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             full_q;
  logic             ovf_q;
  logic             pop;
  logic             push;

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = push_req & (~full_q | pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign out_data  = mem[rd_ptr];
  assign out_count = count;
  assign out_full  = full_q;
  assign out_ovf   = ovf_q;

  // Pointer, occupancy, storage and flag updates; pointers wrap at QDEPTH.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      // NOTE: storage is cleared on reset so out_data reads 0 afterwards;
      // a plain RAM would normally be left unreset.
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      qreg   <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read above sees
      // the pre-edge value regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
        qreg        <= din;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_req & ~push) ovf_q <= 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == CW'(QDEPTH));
    end
  end

endmodule

// File: rtl/regfile_outq.sv
// regfile_outq: NREGS x WIDTH general registers on a shared tri-state dbus,
// feeding an output queue with a valid/ready sink interface.
// Build option: define REGFILE_XINC_EN to add the x_inc port, which
// increments register XIDX (a load to that register wins).
module regfile_outq
  import regfile_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  NREGS  = 4,
  parameter int  XIDX   = 2,
  parameter int  QDEPTH = 4,
  localparam int SELW   = sel_width(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [SELW-1:0]          load_sel,
  input  logic                     assert_en,
  input  logic [SELW-1:0]          assert_sel,
  input  logic                     do_out,
`ifdef REGFILE_XINC_EN
  input  logic                     x_inc,
`endif
  inout  wire  [WIDTH-1:0]         dbus,
  output logic [NREGS*WIDTH-1:0]   regs,
  output logic [WIDTH-1:0]         qreg,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(QDEPTH):0]  out_count,
  output logic                     out_full,
  output logic                     out_ovf
);

  logic [WIDTH-1:0]   rf [NREGS];
  logic [CW_BITS-1:0] cw;
  logic [WIDTH-1:0]   bus_val;
  logic               bus_drive;
  logic               load_ok;

  assign cw[CW_LOAD]   = load_en;
  assign cw[CW_ASSERT] = assert_en;
  assign cw[CW_OUT]    = do_out;

  // The bus is released while reset is high even if assert_en is set.
  assign bus_drive = cw[CW_ASSERT] & (reset != RESET_ACTIVE);
  assign load_ok   = cw[CW_LOAD] & (32'(load_sel) < NREGS);

  // Source mux for the bus driver; an out-of-range select drives 0.
  always_comb begin
    // NOTE: default first so every path assigns bus_val and no latch is inferred.
    bus_val = '0;
    if (32'(assert_sel) < NREGS) bus_val = rf[assert_sel];
  end

  assign dbus = bus_drive ? bus_val : 'z;

`ifdef REGFILE_XINC_EN
  logic x_step;
  assign x_step = x_inc & ~(load_ok & (load_sel == SELW'(XIDX)));
`endif

  // Register file: load from dbus, optional X increment, full clear on reset.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (load_ok) rf[load_sel] <= dbus;
`ifdef REGFILE_XINC_EN
      if (x_step) rf[XIDX] <= rf[XIDX] + WIDTH'(1);
`endif
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs[g*WIDTH +: WIDTH] = rf[g];
  end

  out_queue #(
    .WIDTH  (WIDTH),
    .QDEPTH (QDEPTH)
  ) u_out_queue (
    .clk       (clk),
    .reset     (reset),
    .push_req  (cw[CW_OUT]),
    .din       (dbus),
    .out_ready (out_ready),
    .qreg      (qreg),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_full  (out_full),
    .out_ovf   (out_ovf)
  );

endmodule

// File: tb/tb_regfile_outq.sv
// Self-checking bench for regfile_outq: directed scenarios followed by a
// randomized run against a queue-based behavioural model.
module tb_regfile_outq;

  localparam int WIDTH  = 8;
  localparam int NREGS  = 4;
  localparam int XIDX   = 2;
  localparam int QDEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load_en, assert_en, do_out, out_ready;
  logic [1:0] load_sel, assert_sel;
`ifdef REGFILE_XINC_EN
  logic       x_inc;
`endif
  logic       tb_en;
  logic [7:0] tb_val;
  wire  [7:0] dbus;
  assign dbus = tb_en ? tb_val : 'z;

  logic [31:0] regs;
  logic [7:0]  qreg, out_data;
  logic        out_valid, out_full, out_ovf;
  logic [2:0]  out_count;

  regfile_outq #(
    .WIDTH(WIDTH), .NREGS(NREGS), .XIDX(XIDX), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_sel(load_sel),
    .assert_en(assert_en), .assert_sel(assert_sel),
    .do_out(do_out),
`ifdef REGFILE_XINC_EN
    .x_inc(x_inc),
`endif
    .dbus(dbus), .regs(regs), .qreg(qreg),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_full(out_full), .out_ovf(out_ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [7:0] m_regs [NREGS];
  logic [7:0] mq [$];
  logic       m_ovf;
  logic [7:0] m_qreg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; load_en = 1'b0; assert_en = 1'b0; do_out = 1'b0; out_ready = 1'b0;
    load_sel = '0; assert_sel = '0; tb_en = 1'b1; tb_val = '0;
`ifdef REGFILE_XINC_EN
    x_inc = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    mq.delete();
    m_ovf  = 1'b0;
    m_qreg = '0;
  endtask

  task automatic push_val(input logic [7:0] v);
    tb_en = 1'b1; tb_val = v; do_out = 1'b1;
    tick();
    do_out = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (regs !== 32'h0) begin n_err++; $display("FAIL reset_regs: got %h expected %h", regs, 32'h0); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
    n_vec++; if (qreg !== 8'h00 || out_data !== 8'h00) begin n_err++; $display("FAIL reset_qreg_data: got %h/%h expected 00/00", qreg, out_data); end
  endtask

  task automatic test_load_assert();
    idle();
    tb_val = 8'h3C; load_en = 1'b1; load_sel = 2'd0;
    tick();
    load_en = 1'b0;
    n_vec++; if (regs[7:0] !== 8'h3C) begin n_err++; $display("FAIL load_reg0: got %h expected 3c", regs[7:0]); end
    tb_en = 1'b0; assert_en = 1'b1; assert_sel = 2'd0;
    #1;
    n_vec++; if (dbus !== 8'h3C) begin n_err++; $display("FAIL assert_bus: got %h expected 3c", dbus); end
    assert_en = 1'b0; tb_en = 1'b1; tb_val = 8'h00;
    #1;
    n_vec++; if (dbus !== 8'h00) begin n_err++; $display("FAIL bus_released: got %h expected 00", dbus); end
    tick();
  endtask

  task automatic test_overflow_drain();
    logic [7:0] exp_v [4];
    exp_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) push_val(exp_v[i]);
    n_vec++; if (out_full !== 1'b1 || out_count !== 3'd4) begin n_err++; $display("FAIL fill: got full=%b count=%0d expected full=1 count=4", out_full, out_count); end
    push_val(8'h55);
    n_vec++; if (out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", out_ovf); end
    n_vec++; if (qreg !== 8'h44 || out_count !== 3'd4) begin n_err++; $display("FAIL drop_keeps: got qreg=%h count=%0d expected 44/4", qreg, out_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_v[i]) begin n_err++; $display("FAIL drain_%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, exp_v[i]); end
      tick();
    end
    n_vec++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin n_err++; $display("FAIL drained: got valid=%b count=%0d expected 0/0", out_valid, out_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_v [4];
    exp_v = '{8'h22, 8'h33, 8'h44, 8'h66};
    do_reset();
    push_val(8'h11); push_val(8'h22); push_val(8'h33); push_val(8'h44);
    tb_val = 8'h66; do_out = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++; if (out_data !== 8'h11) begin n_err++; $display("FAIL fullpp_head: got %h expected 11", out_data); end
    tick();
    do_out = 1'b0; out_ready = 1'b0;
    n_vec++; if (out_count !== 3'd4 || out_full !== 1'b1) begin n_err++; $display("FAIL fullpp_count: got count=%0d full=%b expected 4/1", out_count, out_full); end
    n_vec++; if (out_ovf !== 1'b0 || qreg !== 8'h66) begin n_err++; $display("FAIL fullpp_accept: got ovf=%b qreg=%h expected 0/66", out_ovf, qreg); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (out_data !== exp_v[i]) begin n_err++; $display("FAIL fullpp_drain_%0d: got %h expected %h", i, out_data, exp_v[i]); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_same_reg();
    idle();
    tb_val = 8'h5A; load_en = 1'b1; load_sel = 2'd1;
    tick();
    tb_en = 1'b0; assert_en = 1'b1; assert_sel = 2'd1;
    #1;
    n_vec++; if (dbus !== 8'h5A) begin n_err++; $display("FAIL same_bus: got %h expected 5a", dbus); end
    tick();
    idle();
    n_vec++; if (regs[15:8] !== 8'h5A) begin n_err++; $display("FAIL same_reg1: got %h expected 5a", regs[15:8]); end
  endtask

`ifdef REGFILE_XINC_EN
  task automatic test_xinc();
    idle();
    tb_val = 8'hFF; load_en = 1'b1; load_sel = 2'd2;
    tick();
    load_en = 1'b0; x_inc = 1'b1;
    tick();
    n_vec++; if (regs[23:16] !== 8'h00) begin n_err++; $display("FAIL xinc_wrap: got %h expected 00", regs[23:16]); end
    tb_val = 8'h07; load_en = 1'b1; load_sel = 2'd2;
    tick();
    idle();
    n_vec++; if (regs[23:16] !== 8'h07) begin n_err++; $display("FAIL xinc_load_wins: got %h expected 07", regs[23:16]); end
  endtask
`endif

  task automatic test_reset_midop();
    do_reset();
    tb_val = 8'hA5; load_en = 1'b1; load_sel = 2'd0;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 5; i++) push_val(8'(8'h70 + i));
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    n_vec++; if (out_count !== 3'd2 || out_ovf !== 1'b1) begin n_err++; $display("FAIL midop_pre: got count=%0d ovf=%b expected 2/1", out_count, out_ovf); end
    reset = 1'b1; assert_en = 1'b1; assert_sel = 2'd0; tb_en = 1'b1; tb_val = 8'h00;
    #1;
    n_vec++; if (dbus !== 8'h00) begin n_err++; $display("FAIL reset_no_drive: got %h expected 00", dbus); end
    tick();
    idle();
    n_vec++; if (out_valid !== 1'b0 || out_count !== 3'd0 || out_ovf !== 1'b0) begin n_err++; $display("FAIL midop_q: got valid=%b count=%0d ovf=%b expected 0/0/0", out_valid, out_count, out_ovf); end
    n_vec++; if (regs !== 32'h0) begin n_err++; $display("FAIL midop_regs: got %h expected 0", regs); end
  endtask

  task automatic test_random(input int n);
    logic [7:0]  exp_bus;
    logic [31:0] exp_regs;
    bit          pop, push, full;
    do_reset();
    model_clear();
    for (int c = 0; c < n; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      load_en    = 1'($urandom_range(0, 1));
      load_sel   = 2'($urandom_range(0, 3));
      assert_en  = ($urandom_range(0, 2) != 0);
      assert_sel = 2'($urandom_range(0, 3));
      do_out     = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 2) == 0);
      tb_val     = 8'($urandom);
      tb_en      = !(assert_en && !reset);
`ifdef REGFILE_XINC_EN
      x_inc      = 1'($urandom_range(0, 1));
`endif
      exp_bus = tb_en ? tb_val : m_regs[assert_sel];
      #1;
      n_vec++; if (dbus !== exp_bus) begin n_err++; $display("FAIL rnd_bus c=%0d: got %h expected %h", c, dbus, exp_bus); end
      n_vec++; if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_vec++; if (out_data !== mq[0]) begin n_err++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, out_data, mq[0]); end
      end
      if (reset) begin
        model_clear();
      end else begin
        pop  = (mq.size() != 0) && out_ready;
        full = (mq.size() == QDEPTH);
        push = do_out && (!full || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(exp_bus);
          m_qreg = exp_bus;
        end else if (do_out) begin
          m_ovf = 1'b1;
        end
        if (load_en) m_regs[load_sel] = exp_bus;
`ifdef REGFILE_XINC_EN
        if (x_inc && !(load_en && load_sel == 2'(XIDX))) m_regs[XIDX] = m_regs[XIDX] + 8'd1;
`endif
      end
      tick();
      exp_regs = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
      n_vec++; if (regs !== exp_regs) begin n_err++; $display("FAIL rnd_regs c=%0d: got %h expected %h", c, regs, exp_regs); end
      n_vec++; if (out_count !== 3'(mq.size()) || out_full !== (mq.size() == QDEPTH)) begin n_err++; $display("FAIL rnd_count c=%0d: got %0d/%b expected %0d", c, out_count, out_full, mq.size()); end
      n_vec++; if (out_ovf !== m_ovf || qreg !== m_qreg) begin n_err++; $display("FAIL rnd_ovf_qreg c=%0d: got %b/%h expected %b/%h", c, out_ovf, qreg, m_ovf, m_qreg); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_assert();
    test_overflow_drain();
    test_full_push_pop();
    test_same_reg();
`ifdef REGFILE_XINC_EN
    test_xinc();
`endif
    test_reset_midop();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
